instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction fetch stage of the MIPS pipeline. It holds the program counter and drives the word address into the instruction memory, which has an asynchronous read. It captures the returned word into the IF/ID pipeline register. It also handles stall, branch/jump redirect, halt/resume and out-of-range fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
MEM_WORDS, 128, number of words in instruction memory; fetches at or beyond this index fault
NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID as a bubble

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  32  word index to instruction memory, {2'b00, pc[31:2]}, combinational from pc
imem_data  in  32  instruction word, valid in the same cycle as imem_addr
stall  in  1  hazard unit hold request
redirect  in  1  branch taken or jump; loads redirect_target
redirect_target  in  32  byte address of the new PC
halt_req  in  1  single-cycle pulse; stop fetching
resume  in  1  single-cycle pulse; restart fetching
ifid_instr  out  32  registered instruction
ifid_pc  out  32  registered PC of ifid_instr
ifid_pc4  out  32  registered ifid_pc + 4
ifid_valid  out  1  ifid_instr is a real instruction
halted  out  1  state == HALT
fetch_fault  out  1  state == FAULT
misalign_err  out  1  sticky; a redirect target had non-zero bits [1:0]
fetch_count  out  32  count of valid instructions delivered; wraps modulo 2^32

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC.
  - ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc4=0, ifid_valid=0.
  - fetch_count=0, misalign_err=0.
  - state=BOOT.
- Reset mid-operation: all registers return to reset values immediately. Any in-flight IF/ID contents are discarded.
- FSM states: BOOT, RUN, HALT, FAULT.
- BOOT: lasts one cycle. pc holds, IF/ID keeps bubble. Next state is RUN unconditionally; inputs are ignored.
- RUN, per-cycle priority is redirect > fault > halt_req > stall > normal:
  - redirect:
    - pc <= {redirect_target[31:2],2'b00}.
    - IF/ID <= bubble (valid=0, instr=NOP_INSTR).
    - If redirect_target[1:0]!=0, misalign_err <= 1.
    - Stay in RUN.
  - Fault: pc[31:2] >= MEM_WORDS. IF/ID <= bubble, pc holds, next state FAULT.
  - halt_req: IF/ID <= bubble, pc holds, next state HALT.
  - stall: pc, IF/ID and fetch_count all hold.
  - Normal:
    - ifid_instr <= imem_data, ifid_pc <= pc, ifid_pc4 <= pc+4, ifid_valid <= 1.
    - pc <= pc+4, fetch_count++.
- Latency: an instruction appears on ifid_* one cycle after pc presents its address.
- First valid IF/ID output after reset deassertion occurs at the 2nd rising edge (BOOT, then RUN).
- HALT:
  - IF/ID holds bubble.
  - redirect updates pc (aligned, misalign check applies); state stays HALT.
  - resume: next state RUN, with fetch from the current pc on the following cycle.
  - If redirect and resume arrive together, both take effect.
  - halt_req is ignored.
- FAULT:
  - pc and bubble hold; stall, halt_req and resume are ignored.
  - Only redirect exits, to RUN with pc=target.
- PC arithmetic: 32-bit, pc+4 wraps at 2^32 without flagging. The fault check uses pc[31:2] compared unsigned against MEM_WORDS.
- A stall asserted together with redirect is overridden: the redirect still bubbles.
- misalign_err clears only on reset.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INSTR default.
  - Fetch FSM state enum (fetch_state_t: BOOT, RUN, HALT, FAULT).
  - IF/ID bundle typedef (instr, pc, pc4, valid) for reuse by the decode stage.
- Natural sub-module: ifid_reg, the IF/ID pipeline register with hold/bubble controls. Next-PC logic and FSM stay in instr_fetch.

Test Plan:
- Reset then free run. Bench memory preloads MEM[0]=32'hA00000AA, MEM[1]=32'h10000011, MEM[2]=32'h20000022, with no stall.
  -> Edge 1 after reset: ifid_valid=0.
  -> Edges 2-4: ifid_instr = A00000AA, 10000011, 20000022; ifid_pc = 0, 4, 8; ifid_pc4 = 4, 8, C.
  -> fetch_count=3.
- Stall for 2 cycles while ifid_pc=4.
  -> ifid_instr stays 10000011 and pc stays 8 both cycles.
  -> Release: next edge gives 20000022.
- Redirect to 32'h24 asserted together with stall.
  -> Next edge: ifid_valid=0, pc=0x24.
  -> Following edge: ifid_pc=0x24, ifid_instr=MEM[9]; misalign_err=0.
- Redirect to 32'h1E.
  -> pc=0x1C, misalign_err=1 and stays set after further redirects until rst_n pulse.
- Redirect to 32'h200 (word 128).
  -> Next cycle: fetch_fault=1, ifid_valid=0, pc holds.
  -> halt_req and resume have no effect.
  -> Redirect to 0 returns to RUN; MEM[0] delivered.
- halt_req pulse at pc=8.
  -> halted=1 next cycle, bubbles only.
  -> resume pulse: halted=0, then 20000022 delivered with ifid_pc=8.
  -> Separately, rst_n low mid-HALT: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: fetch FSM state, IF/ID bundle, bubble encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    // Encoding written into IF/ID when the slot carries no instruction.
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // IF/ID pipeline bundle, also consumed by the decode stage.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port, pipeline control, IF/ID and status.
// Latency: n/a (wiring only).
// Backpressure: stall from the hazard unit holds the fetch stage.
//   master: the fetch stage (drives imem_addr, ifid_*, status)
//   slave : the surrounding pipeline / memory (drives imem_data and controls)
interface instr_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
    logic        fetch_fault;
    logic        misalign_err;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr, ifid_instr, ifid_pc, ifid_pc4, ifid_valid,
               halted, fetch_fault, misalign_err, fetch_count,
        input  imem_data, stall, redirect, redirect_target, halt_req, resume
    );

    modport slave (
        input  imem_addr, ifid_instr, ifid_pc, ifid_pc4, ifid_valid,
               halted, fetch_fault, misalign_err, fetch_count,
        output imem_data, stall, redirect, redirect_target, halt_req, resume
    );
endinterface

// File: rtl/instr_fetch_ifid_reg.sv
// IF/ID pipeline register with load / bubble / hold controls.
// Latency: 1 cycle from din to q when load is set.
// Backpressure: neither load nor bubble means hold (stall).
//   ports: clk, rst_n, load, bubble, din (ifid_t), q (ifid_t)
module ifid_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t din,
    output ifid_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '{instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0, valid: 1'b0};
        end else if (bubble) begin
            // pc fields are meaningless in a bubble; leave them untouched.
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= din;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// MIPS instruction fetch: PC, next-PC selection, fetch FSM, IF/ID capture.
// Latency: instruction reaches ifid_* one cycle after its address is presented.
// Backpressure: stall holds pc, IF/ID and fetch_count; redirect overrides stall.
//   ports: clk, rst_n, bus (instr_fetch_if.master: imem, controls, IF/ID, status)
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 128,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_fetch_if.master  bus
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_count_q;
    logic         misalign_q;

    logic         ifid_load;
    logic         ifid_bubble;
    logic         count_inc;
    logic         misalign_set;
    logic         pc_oob;
    logic [31:0]  redirect_pc;
    ifid_t        ifid_din;
    ifid_t        ifid_q;

    // Word index of the current pc; compared unsigned against the memory size.
    assign pc_oob      = ({2'b00, pc_q[31:2]} >= MEM_LIMIT);
    assign redirect_pc = {bus.redirect_target[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        count_inc    = 1'b0;
        misalign_set = 1'b0;

        case (state_q)
            BOOT: begin
                // One settling cycle; IF/ID still carries the reset bubble.
                state_d = RUN;
            end
            RUN: begin
                if (bus.redirect) begin
                    pc_d         = redirect_pc;
                    ifid_bubble  = 1'b1;
                    misalign_set = |bus.redirect_target[1:0];
                end else if (pc_oob) begin
                    ifid_bubble = 1'b1;
                    state_d     = FAULT;
                end else if (bus.halt_req) begin
                    ifid_bubble = 1'b1;
                    state_d     = HALT;
                end else if (!bus.stall) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + 32'd4;
                    count_inc = 1'b1;
                end
            end
            HALT: begin
                ifid_bubble = 1'b1;
                // redirect and resume are independent: both may act together.
                if (bus.redirect) begin
                    pc_d         = redirect_pc;
                    misalign_set = |bus.redirect_target[1:0];
                end
                if (bus.resume) begin
                    state_d = RUN;
                end
            end
            FAULT: begin
                ifid_bubble = 1'b1;
                if (bus.redirect) begin
                    pc_d         = redirect_pc;
                    misalign_set = |bus.redirect_target[1:0];
                    state_d      = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'h0;
            misalign_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (count_inc) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (misalign_set) begin
                misalign_q <= 1'b1;
            end
        end
    end

    assign ifid_din = '{instr: bus.imem_data, pc: pc_q, pc4: pc_q + 32'd4, valid: 1'b1};

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .din    (ifid_din),
        .q      (ifid_q)
    );

    assign bus.imem_addr    = {2'b00, pc_q[31:2]};
    assign bus.ifid_instr   = ifid_q.instr;
    assign bus.ifid_pc      = ifid_q.pc;
    assign bus.ifid_pc4     = ifid_q.pc4;
    assign bus.ifid_valid   = ifid_q.valid;
    assign bus.halted       = (state_q == HALT);
    assign bus.fetch_fault  = (state_q == FAULT);
    assign bus.misalign_err = misalign_q;
    assign bus.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-cycle vector table through a scoreboard queue,
// plus a hand-written asynchronous reset in the middle of HALT.
module tb_instr_fetch;
    import mips_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk;
    logic rst_n;
    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (128),
        .NOP_INSTR (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:127];
    assign bus.imem_data = (bus.imem_addr < 32'd128) ? mem[bus.imem_addr[6:0]] : 32'hDEAD_BEEF;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] tgt;
        logic        hr;
        logic        rs;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [31:0] ea;
        logic        eh;
        logic        ef;
        logic        em;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic vec_t mk(logic st, logic rd, logic [31:0] tgt, logic hr, logic rs,
                                logic ev, logic [31:0] ei, logic [31:0] ep, logic [31:0] ea,
                                logic eh, logic ef, logic em, logic [31:0] ec);
        vec_t v;
        v.st = st; v.rd = rd; v.tgt = tgt; v.hr = hr; v.rs = rs;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea;
        v.eh = eh; v.ef = ef; v.em = em; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.stall           = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
        bus.halt_req        = 1'b0;
        bus.resume          = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".valid"},    {31'h0, bus.ifid_valid},   32'h0);
        chk({tag, ".instr"},    bus.ifid_instr,            NOP);
        chk({tag, ".pc"},       bus.ifid_pc,               32'h0);
        chk({tag, ".pc4"},      bus.ifid_pc4,              32'h0);
        chk({tag, ".addr"},     bus.imem_addr,             32'h0);
        chk({tag, ".count"},    bus.fetch_count,           32'h0);
        chk({tag, ".misalign"}, {31'h0, bus.misalign_err}, 32'h0);
        chk({tag, ".halted"},   {31'h0, bus.halted},       32'h0);
        chk({tag, ".fault"},    {31'h0, bus.fetch_fault},  32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        for (int i = 0; i < 128; i++) mem[i] = 32'hC000_0000 | 32'(i);
        mem[0] = 32'hA000_00AA;
        mem[1] = 32'h1000_0011;
        mem[2] = 32'h2000_0022;

        //               st rd tgt           hr rs  ev instr          pc            addr    h  f  m  cnt
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  0, NOP,          32'h0,        32'd0,   0, 0, 0, 32'd0));  // BOOT
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  1, 32'hA00000AA, 32'h0,        32'd1,   0, 0, 0, 32'd1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  1, 32'h10000011, 32'h4,        32'd2,   0, 0, 0, 32'd2));
        tbl.push_back(mk(1, 0, 32'h0,        0, 0,  1, 32'h10000011, 32'h4,        32'd2,   0, 0, 0, 32'd2));  // stall
        tbl.push_back(mk(1, 0, 32'h0,        0, 0,  1, 32'h10000011, 32'h4,        32'd2,   0, 0, 0, 32'd2));  // stall
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  1, 32'h20000022, 32'h8,        32'd3,   0, 0, 0, 32'd3));
        tbl.push_back(mk(1, 1, 32'h24,       0, 0,  0, NOP,          32'h0,        32'd9,   0, 0, 0, 32'd3));  // stall+redirect
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  1, 32'hC0000009, 32'h24,       32'd10,  0, 0, 0, 32'd4));
        tbl.push_back(mk(0, 1, 32'h1E,       0, 0,  0, NOP,          32'h0,        32'd7,   0, 0, 1, 32'd4));  // misaligned
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  1, 32'hC0000007, 32'h1C,       32'd8,   0, 0, 1, 32'd5));
        tbl.push_back(mk(0, 1, 32'h200,      0, 0,  0, NOP,          32'h0,        32'd128, 0, 0, 1, 32'd5));  // word 128
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  0, NOP,          32'h0,        32'd128, 0, 1, 1, 32'd5));  // -> FAULT
        tbl.push_back(mk(0, 0, 32'h0,        1, 0,  0, NOP,          32'h0,        32'd128, 0, 1, 1, 32'd5));  // halt ignored
        tbl.push_back(mk(0, 0, 32'h0,        0, 1,  0, NOP,          32'h0,        32'd128, 0, 1, 1, 32'd5));  // resume ignored
        tbl.push_back(mk(1, 0, 32'h0,        0, 0,  0, NOP,          32'h0,        32'd128, 0, 1, 1, 32'd5));  // stall ignored
        tbl.push_back(mk(0, 1, 32'h0,        0, 0,  0, NOP,          32'h0,        32'd0,   0, 0, 1, 32'd5));  // exit FAULT
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  1, 32'hA00000AA, 32'h0,        32'd1,   0, 0, 1, 32'd6));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  1, 32'h10000011, 32'h4,        32'd2,   0, 0, 1, 32'd7));
        tbl.push_back(mk(0, 0, 32'h0,        1, 0,  0, NOP,          32'h0,        32'd2,   1, 0, 1, 32'd7));  // halt at pc=8
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  0, NOP,          32'h0,        32'd2,   1, 0, 1, 32'd7));
        tbl.push_back(mk(0, 0, 32'h0,        1, 0,  0, NOP,          32'h0,        32'd2,   1, 0, 1, 32'd7));  // halt_req ignored
        tbl.push_back(mk(0, 0, 32'h0,        0, 1,  0, NOP,          32'h0,        32'd2,   0, 0, 1, 32'd7));  // resume
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  1, 32'h20000022, 32'h8,        32'd3,   0, 0, 1, 32'd8));
        tbl.push_back(mk(0, 0, 32'h0,        1, 0,  0, NOP,          32'h0,        32'd3,   1, 0, 1, 32'd8));
        tbl.push_back(mk(0, 1, 32'h40,       0, 1,  0, NOP,          32'h0,        32'd16,  0, 0, 1, 32'd8));  // redirect+resume
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  1, 32'hC0000010, 32'h40,       32'd17,  0, 0, 1, 32'd9));
        tbl.push_back(mk(0, 0, 32'h0,        1, 0,  0, NOP,          32'h0,        32'd17,  1, 0, 1, 32'd9));
        tbl.push_back(mk(0, 1, 32'h33,       0, 0,  0, NOP,          32'h0,        32'd12,  1, 0, 1, 32'd9));  // redirect in HALT
        tbl.push_back(mk(0, 1, 32'h1FC,      0, 0,  0, NOP,          32'h0,        32'd127, 1, 0, 1, 32'd9));
        tbl.push_back(mk(0, 0, 32'h0,        0, 1,  0, NOP,          32'h0,        32'd127, 0, 0, 1, 32'd9));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  1, 32'hC000007F, 32'h1FC,      32'd128, 0, 0, 1, 32'd10)); // last word ok
        tbl.push_back(mk(0, 0, 32'h0,        0, 0,  0, NOP,          32'h0,        32'd128, 0, 1, 1, 32'd10)); // run off end
        tbl.push_back(mk(0, 1, 32'h8,        0, 0,  0, NOP,          32'h0,        32'd2,   0, 0, 1, 32'd10));
        tbl.push_back(mk(0, 0, 32'h0,        1, 0,  0, NOP,          32'h0,        32'd2,   1, 0, 1, 32'd10)); // HALT again

        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.stall           = tbl[i].st;
            bus.redirect        = tbl[i].rd;
            bus.redirect_target = tbl[i].tgt;
            bus.halt_req        = tbl[i].hr;
            bus.resume          = tbl[i].rs;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d.valid", i),    {31'h0, bus.ifid_valid},   {31'h0, e.ev});
            chk($sformatf("v%0d.instr", i),    bus.ifid_instr,            e.ei);
            if (e.ev) begin
                chk($sformatf("v%0d.pc", i),   bus.ifid_pc,               e.ep);
                chk($sformatf("v%0d.pc4", i),  bus.ifid_pc4,              e.ep + 32'd4);
            end
            chk($sformatf("v%0d.addr", i),     bus.imem_addr,             e.ea);
            chk($sformatf("v%0d.halted", i),   {31'h0, bus.halted},       {31'h0, e.eh});
            chk($sformatf("v%0d.fault", i),    {31'h0, bus.fetch_fault},  {31'h0, e.ef});
            chk($sformatf("v%0d.misalign", i), {31'h0, bus.misalign_err}, {31'h0, e.em});
            chk($sformatf("v%0d.count", i),    bus.fetch_count,           e.ec);
            @(negedge clk);
            drive_idle();
        end

        // Asynchronous reset in the middle of HALT, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("halt_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst.boot_valid", {31'h0, bus.ifid_valid}, 32'h0);
        chk("post_rst.halted",     {31'h0, bus.halted},     32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("post_rst.valid",    {31'h0, bus.ifid_valid},   32'h1);
        chk("post_rst.instr",    bus.ifid_instr,            32'hA000_00AA);
        chk("post_rst.pc",       bus.ifid_pc,               32'h0);
        chk("post_rst.count",    bus.fetch_count,           32'd1);
        chk("post_rst.misalign", {31'h0, bus.misalign_err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
